// File: rtl/rs_encode_stream_in_ctrl.sv
// Input-side controller of the RS block stream encoder.
// Accepts one request (block count) at a time, forwards the count to the
// output controller, then passes source data lines straight through to the
// line encoder, tagging the first and last line of every RS block.
//
// Handshake rule on every channel: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. A producer keeps
// valid and its payload stable until that transfer. Ready never depends
// on this module's own valid output.
module rs_encode_stream_in_ctrl #(
  parameter int DATA_W          = 256,
  parameter int LINES_PER_BLOCK = 8,
  parameter int BLOCK_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // request metadata from the source
  input  logic                   src_stream_encoder_req_val,
  input  logic [BLOCK_CNT_W-1:0] src_stream_encoder_req_num_blocks,
  output logic                   stream_encoder_src_req_rdy,
  // data lines from the source
  input  logic                   src_stream_encoder_req_data_val,
  input  logic [DATA_W-1:0]      src_stream_encoder_req_data,
  output logic                   stream_encoder_src_req_data_rdy,
  // lines to the line encoder
  output logic                   stream_encode_line_encode_val,
  output logic [DATA_W-1:0]      stream_encode_line_encode_data,
  output logic                   stream_encode_line_encode_first,
  output logic                   stream_encode_line_encode_last,
  input  logic                   line_encode_stream_encode_rdy,
  // metadata to the output controller
  output logic                   in_ctrl_out_ctrl_val,
  output logic [BLOCK_CNT_W-1:0] in_ctrl_out_ctrl_num_blocks,
  input  logic                   out_ctrl_in_ctrl_rdy,
  // FSM state, exposed for checkers (encoding of state_t)
  output logic [1:0]             debug_state
);

  localparam int LINE_CNT_W = (LINES_PER_BLOCK > 1) ? $clog2(LINES_PER_BLOCK) : 1;
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    READY      = 2'd0,
    SEND_META  = 2'd1,
    PASS_LINES = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic [BLOCK_CNT_W-1:0] block_cnt;
  logic [BLOCK_CNT_W-1:0] num_blocks;

  // Index of the final block of the request. Only used in PASS_LINES, where
  // num_blocks is at least 1, so the subtraction never wraps.
  logic [BLOCK_CNT_W-1:0] last_block;
  logic                   at_last_line;
  logic                   at_last_block;
  logic                   req_accept;
  logic                   line_xfer;

  assign last_block    = num_blocks - BLOCK_CNT_W'(1);
  assign at_last_line  = (line_cnt == LAST_LINE);
  assign at_last_block = (block_cnt == last_block);
  assign req_accept    = stream_encoder_src_req_rdy & src_stream_encoder_req_val;
  assign line_xfer     = stream_encode_line_encode_val & stream_encoder_src_req_data_rdy;

  assign in_ctrl_out_ctrl_num_blocks = num_blocks;
  assign debug_state                 = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= READY;
    end else begin
      state <= state_next;
    end
  end

  // Request latch and line/block counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_blocks <= '0;
      line_cnt   <= '0;
      block_cnt  <= '0;
    end else if (req_accept) begin
      num_blocks <= src_stream_encoder_req_num_blocks;
      line_cnt   <= '0;
      block_cnt  <= '0;
    end else if (line_xfer) begin
      if (at_last_line) begin
        line_cnt  <= '0;
        block_cnt <= block_cnt + BLOCK_CNT_W'(1);
      end else begin
        line_cnt <= line_cnt + LINE_CNT_W'(1);
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next                      = state;
    stream_encoder_src_req_rdy      = 1'b0;
    stream_encoder_src_req_data_rdy = 1'b0;
    stream_encode_line_encode_val   = 1'b0;
    stream_encode_line_encode_data  = src_stream_encoder_req_data;
    stream_encode_line_encode_first = 1'b0;
    stream_encode_line_encode_last  = 1'b0;
    in_ctrl_out_ctrl_val            = 1'b0;

    case (state)
      READY: begin
        stream_encoder_src_req_rdy = 1'b1;
        // A zero-block request is consumed here and produces nothing.
        if (src_stream_encoder_req_val && (src_stream_encoder_req_num_blocks != '0)) begin
          state_next = SEND_META;
        end
      end

      SEND_META: begin
        in_ctrl_out_ctrl_val = 1'b1;
        if (out_ctrl_in_ctrl_rdy) begin
          state_next = PASS_LINES;
        end
      end

      PASS_LINES: begin
        // Zero-latency pass-through; first/last qualified by valid.
        stream_encode_line_encode_val   = src_stream_encoder_req_data_val;
        stream_encoder_src_req_data_rdy = line_encode_stream_encode_rdy;
        stream_encode_line_encode_first = src_stream_encoder_req_data_val & (line_cnt == '0);
        stream_encode_line_encode_last  = src_stream_encoder_req_data_val & at_last_line;
        if (src_stream_encoder_req_data_val && line_encode_stream_encode_rdy &&
            at_last_line && at_last_block) begin
          state_next = READY;
        end
      end

      default: begin
        state_next                      = state_t'('x);
        stream_encoder_src_req_rdy      = 1'bx;
        stream_encoder_src_req_data_rdy = 1'bx;
        stream_encode_line_encode_val   = 1'bx;
        stream_encode_line_encode_data  = 'x;
        stream_encode_line_encode_first = 1'bx;
        stream_encode_line_encode_last  = 1'bx;
        in_ctrl_out_ctrl_val            = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_rs_encode_stream_in_ctrl.sv
// Bench for rs_encode_stream_in_ctrl with 4 lines per block.
module tb_rs_encode_stream_in_ctrl;

  localparam int DW  = 256;
  localparam int LPB = 4;
  localparam int BW  = 16;

  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_META  = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_val;
  logic [BW-1:0] req_nb;
  logic          req_rdy;
  logic          data_val;
  logic [DW-1:0] data;
  logic          data_rdy;
  logic          enc_val;
  logic [DW-1:0] enc_data;
  logic          enc_first;
  logic          enc_last;
  logic          enc_rdy;
  logic          meta_val;
  logic [BW-1:0] meta_nb;
  logic          oc_rdy;
  logic [1:0]    dstate;

  rs_encode_stream_in_ctrl #(
    .DATA_W(DW), .LINES_PER_BLOCK(LPB), .BLOCK_CNT_W(BW)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .src_stream_encoder_req_val        (req_val),
    .src_stream_encoder_req_num_blocks (req_nb),
    .stream_encoder_src_req_rdy        (req_rdy),
    .src_stream_encoder_req_data_val   (data_val),
    .src_stream_encoder_req_data       (data),
    .stream_encoder_src_req_data_rdy   (data_rdy),
    .stream_encode_line_encode_val     (enc_val),
    .stream_encode_line_encode_data    (enc_data),
    .stream_encode_line_encode_first   (enc_first),
    .stream_encode_line_encode_last    (enc_last),
    .line_encode_stream_encode_rdy     (enc_rdy),
    .in_ctrl_out_ctrl_val              (meta_val),
    .in_ctrl_out_ctrl_num_blocks       (meta_nb),
    .out_ctrl_in_ctrl_rdy              (oc_rdy),
    .debug_state                       (dstate)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] line_word(input int k);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(k) * 32'h0101_0007;
    return {8{w}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_val  = 1'b0;
    req_nb   = '0;
    data_val = 1'b0;
    data     = '0;
    enc_rdy  = 1'b0;
    oc_rdy   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request from READY and drives it to completion.
  // Caller starts at a negedge with the DUT in READY.
  task automatic run_request(input int nb, input bit rnd, input int stall);
    int beat;
    int cyc;
    req_val = 1'b1;
    req_nb  = BW'(nb);
    #1;
    chk("req_rdy_on_request", {255'b0, req_rdy}, 1);
    @(negedge clk);
    req_val = 1'b0;
    if (nb == 0) begin
      #1;
      chk("zero_req_state", {254'b0, dstate}, S_READY);
      chk("zero_req_meta_val", {255'b0, meta_val}, 0);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      oc_rdy   = 1'b0;
      data_val = 1'b1;
      enc_rdy  = 1'b1;
      data     = line_word(999);
      #1;
      chk("stall_meta_val", {255'b0, meta_val}, 1);
      chk("stall_meta_nb", {240'b0, meta_nb}, BW'(nb));
      chk("stall_data_rdy", {255'b0, data_rdy}, 0);
      chk("stall_enc_val", {255'b0, enc_val}, 0);
      @(negedge clk);
    end
    oc_rdy   = 1'b1;
    data_val = 1'b0;
    #1;
    chk("meta_val", {255'b0, meta_val}, 1);
    chk("meta_nb", {240'b0, meta_nb}, BW'(nb));
    @(negedge clk);
    oc_rdy = 1'b0;
    for (int k = 0; k < nb * LPB; k++) exp_q.push_back(line_word(k + nb * 100));
    beat = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      data_val = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      enc_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data     = exp_q[0];
      #1;
      if (data_val && enc_rdy) begin
        chk("line_enc_val", {255'b0, enc_val}, 1);
        chk("line_data", enc_data, exp_q[0]);
        chk("line_first", {255'b0, enc_first}, ((beat % LPB) == 0) ? 1 : 0);
        chk("line_last", {255'b0, enc_last}, ((beat % LPB) == LPB - 1) ? 1 : 0);
        void'(exp_q.pop_front());
        beat++;
      end else begin
        chk("wait_enc_val", {255'b0, enc_val}, {255'b0, data_val});
        chk("wait_data_rdy", {255'b0, data_rdy}, {255'b0, enc_rdy});
        if (!data_val) chk("wait_first_last", {254'b0, enc_first, enc_last}, 0);
      end
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("line_timeout_remaining", exp_q.size(), 0);
      exp_q.delete();
    end
    data_val = 1'b1;
    enc_rdy  = 1'b1;
    #1;
    chk("done_state", {254'b0, dstate}, S_READY);
    chk("done_req_rdy", {255'b0, req_rdy}, 1);
    chk("done_enc_val", {255'b0, enc_val}, 0);
    chk("done_beats", beat, nb * LPB);
    idle_inputs();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          req_val;
    logic [BW-1:0] nb;
    logic          data_val;
    logic [DW-1:0] data;
    logic          enc_rdy;
    logic          oc_rdy;
    logic          e_req_rdy;
    logic          e_data_rdy;
    logic          e_enc_val;
    logic          e_first;
    logic          e_last;
    logic          e_meta_val;
    logic [BW-1:0] e_meta_nb;
    logic [1:0]    e_state;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic rv, input logic [BW-1:0] nb, input logic dv,
                              input logic [DW-1:0] d, input logic er, input logic ocr,
                              input logic e_rr, input logic e_dr, input logic e_ev,
                              input logic e_f, input logic e_l, input logic e_mv,
                              input logic [BW-1:0] e_mnb, input logic [1:0] e_st);
    vec_t v;
    v.req_val = rv; v.nb = nb; v.data_val = dv; v.data = d; v.enc_rdy = er; v.oc_rdy = ocr;
    v.e_req_rdy = e_rr; v.e_data_rdy = e_dr; v.e_enc_val = e_ev; v.e_first = e_f;
    v.e_last = e_l; v.e_meta_val = e_mv; v.e_meta_nb = e_mnb; v.e_state = e_st;
    return v;
  endfunction

  // ---------------- main ----------------
  initial begin
    idle_inputs();
    //                rv nb  dv data          er oc   rr dr ev f  l  mv mnb st
    vecs[0]  = mk(0, 0, 0, '0,           0, 0,   1, 0, 0, 0, 0, 0, 0, S_READY);
    vecs[1]  = mk(1, 0, 0, '0,           0, 1,   1, 0, 0, 0, 0, 0, 0, S_READY);
    vecs[2]  = mk(0, 0, 1, line_word(1), 1, 1,   1, 0, 0, 0, 0, 0, 0, S_READY);
    vecs[3]  = mk(1, 1, 0, '0,           0, 0,   1, 0, 0, 0, 0, 0, 0, S_READY);
    vecs[4]  = mk(1, 5, 0, '0,           0, 0,   0, 0, 0, 0, 0, 1, 1, S_META);
    vecs[5]  = mk(0, 0, 1, line_word(2), 1, 1,   0, 0, 0, 0, 0, 1, 1, S_META);
    vecs[6]  = mk(0, 0, 1, line_word(3), 1, 0,   0, 1, 1, 1, 0, 0, 1, S_PASS);
    vecs[7]  = mk(0, 0, 1, line_word(4), 0, 0,   0, 0, 1, 0, 0, 0, 1, S_PASS);
    vecs[8]  = mk(0, 0, 0, line_word(4), 1, 0,   0, 1, 0, 0, 0, 0, 1, S_PASS);
    vecs[9]  = mk(0, 0, 1, line_word(4), 1, 0,   0, 1, 1, 0, 0, 0, 1, S_PASS);
    vecs[10] = mk(0, 0, 1, line_word(5), 1, 0,   0, 1, 1, 0, 0, 0, 1, S_PASS);
    vecs[11] = mk(0, 0, 1, line_word(6), 1, 0,   0, 1, 1, 0, 1, 0, 1, S_PASS);
    vecs[12] = mk(0, 0, 0, '0,           0, 0,   1, 0, 0, 0, 0, 0, 1, S_READY);

    do_reset();
    #1;
    chk("reset_req_rdy", {255'b0, req_rdy}, 1);
    chk("reset_data_rdy", {255'b0, data_rdy}, 0);
    chk("reset_enc_val", {255'b0, enc_val}, 0);
    chk("reset_first_last", {254'b0, enc_first, enc_last}, 0);
    chk("reset_meta_val", {255'b0, meta_val}, 0);
    chk("reset_meta_nb", {240'b0, meta_nb}, 0);
    chk("reset_state", {254'b0, dstate}, S_READY);
    @(negedge clk);

    // Single-block request, zero-block request and metadata back-pressure.
    for (int i = 0; i < 13; i++) begin
      req_val  = vecs[i].req_val;
      req_nb   = vecs[i].nb;
      data_val = vecs[i].data_val;
      data     = vecs[i].data;
      enc_rdy  = vecs[i].enc_rdy;
      oc_rdy   = vecs[i].oc_rdy;
      #1;
      chk($sformatf("v%0d_req_rdy", i), {255'b0, req_rdy}, {255'b0, vecs[i].e_req_rdy});
      chk($sformatf("v%0d_data_rdy", i), {255'b0, data_rdy}, {255'b0, vecs[i].e_data_rdy});
      chk($sformatf("v%0d_enc_val", i), {255'b0, enc_val}, {255'b0, vecs[i].e_enc_val});
      chk($sformatf("v%0d_first", i), {255'b0, enc_first}, {255'b0, vecs[i].e_first});
      chk($sformatf("v%0d_last", i), {255'b0, enc_last}, {255'b0, vecs[i].e_last});
      chk($sformatf("v%0d_meta_val", i), {255'b0, meta_val}, {255'b0, vecs[i].e_meta_val});
      chk($sformatf("v%0d_meta_nb", i), {240'b0, meta_nb}, {240'b0, vecs[i].e_meta_nb});
      chk($sformatf("v%0d_state", i), {254'b0, dstate}, {254'b0, vecs[i].e_state});
      if (vecs[i].e_enc_val) chk($sformatf("v%0d_data", i), enc_data, vecs[i].data);
      @(negedge clk);
    end
    idle_inputs();

    // Three blocks, full rate.
    run_request(3, 1'b0, 0);
    @(negedge clk);
    // Three blocks with randomly toggling source valid / encoder ready.
    run_request(3, 1'b1, 0);
    @(negedge clk);
    // Metadata held off for five cycles.
    run_request(2, 1'b1, 5);
    @(negedge clk);
    // Zero-block request is consumed with no metadata.
    run_request(0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("zero_req_followup_meta_val", {255'b0, meta_val}, 0);
    @(negedge clk);

    // Largest block count latches without overflow.
    req_val = 1'b1;
    req_nb  = 16'hFFFF;
    @(negedge clk);
    req_val = 1'b0;
    #1;
    chk("max_nb_meta_nb", {240'b0, meta_nb}, 16'hFFFF);
    chk("max_nb_state", {254'b0, dstate}, S_META);
    do_reset();

    // Reset in the middle of block 1, after its second line.
    req_val = 1'b1;
    req_nb  = 2;
    @(negedge clk);
    req_val = 1'b0;
    oc_rdy  = 1'b1;
    @(negedge clk);
    oc_rdy   = 1'b0;
    data_val = 1'b1;
    enc_rdy  = 1'b1;
    for (int k = 0; k < LPB + 2; k++) begin
      data = line_word(500 + k);
      #1;
      chk("pre_reset_line_xfer", {254'b0, enc_val, data_rdy}, 2'b11);
      @(negedge clk);
    end
    #1;
    chk("pre_reset_state", {254'b0, dstate}, S_PASS);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_reset_state", {254'b0, dstate}, S_READY);
    chk("mid_reset_req_rdy", {255'b0, req_rdy}, 1);
    chk("mid_reset_enc_val", {255'b0, enc_val}, 0);
    chk("mid_reset_data_rdy", {255'b0, data_rdy}, 0);
    chk("mid_reset_meta_val", {255'b0, meta_val}, 0);
    chk("mid_reset_first_last", {254'b0, enc_first, enc_last}, 0);
    idle_inputs();
    @(negedge clk);
    run_request(1, 1'b0, 0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rs_encode_stream_in_ctrl.md
RS_ENCODE_STREAM_IN_CTRL -- requirements
Module: rs_encode_stream_in_ctrl

Interface
REQ-001 Parameter DATA_W, default 256: width of one data line in bits.
REQ-002 Parameter LINES_PER_BLOCK, default 8: data lines per RS block; legal range is 2 or more.
REQ-003 Parameter BLOCK_CNT_W, default 16: width of the block-count field.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 src_stream_encoder_req_val  in  1  request metadata valid.
REQ-007 src_stream_encoder_req_num_blocks  in  BLOCK_CNT_W  number of RS blocks in the request.
REQ-008 stream_encoder_src_req_rdy  out  1  metadata accepted.
REQ-009 src_stream_encoder_req_data_val  in  1  source data line valid.
REQ-010 src_stream_encoder_req_data  in  DATA_W  source data line.
REQ-011 stream_encoder_src_req_data_rdy  out  1  data line accepted.
REQ-012 stream_encode_line_encode_val  out  1  line to the line encoder is valid.
REQ-013 stream_encode_line_encode_data  out  DATA_W  line payload.
REQ-014 stream_encode_line_encode_first  out  1  line is the first of its block (encoder clears parity state).
REQ-015 stream_encode_line_encode_last  out  1  line is the last of its block.
REQ-016 line_encode_stream_encode_rdy  in  1  line encoder ready.
REQ-017 in_ctrl_out_ctrl_val  out  1  metadata valid to the output controller.
REQ-018 in_ctrl_out_ctrl_num_blocks  out  BLOCK_CNT_W  registered block count.
REQ-019 out_ctrl_in_ctrl_rdy  in  1  output controller accepts metadata.

Function
REQ-020 FSM states: READY, SEND_META, PASS_LINES.
REQ-021 READY:
- stream_encoder_src_req_rdy=1.
- On req_val: latch num_blocks, clear line_cnt and block_cnt.
- If num_blocks==0, consume the request and stay in READY; no metadata and no lines are issued.
- Otherwise go to SEND_META.
REQ-022 SEND_META:
- in_ctrl_out_ctrl_val=1 with the latched count, held stable until out_ctrl_in_ctrl_rdy.
- On that handshake go to PASS_LINES.
- No data lines are accepted in this state.
REQ-023 PASS_LINES:
- stream_encode_line_encode_val = src data_val.
- stream_encoder_src_req_data_rdy = line_encode_stream_encode_rdy.
- data passes through combinationally, zero latency, no buffering.
REQ-024 first = (line_cnt==0); last = (line_cnt==LINES_PER_BLOCK-1). Both are valid only while line_encode val=1 and are 0 otherwise.
REQ-025 On each PASS_LINES handshake (val&rdy):
- line_cnt increments, wrapping to 0 after LINES_PER_BLOCK-1.
- On that wrap, block_cnt increments.
REQ-026 A handshake with last=1 and block_cnt==num_blocks-1 returns the FSM to READY in the next cycle; nothing more is accepted for that request.
REQ-027 Outside PASS_LINES, both stream_encode_line_encode_val and stream_encoder_src_req_data_rdy are 0.
REQ-028 Outside READY, stream_encoder_src_req_rdy=0, so at most one request is in flight.
REQ-029 Counter arithmetic:
- line_cnt is $clog2(LINES_PER_BLOCK) bits, unsigned.
- block_cnt is BLOCK_CNT_W bits, unsigned.
- num_blocks = 2^BLOCK_CNT_W-1 is legal and compares without overflow.
REQ-030 A data_val that arrives while the encoder rdy is low leaves counters unchanged; data must be held by the source.
REQ-031 A request that arrives while not in READY is ignored until READY; rdy low back-pressures it.
REQ-032 Unreachable state encodings drive all outputs and the next state to X.

Reset
REQ-033 While rst is high at a clock edge: state goes to READY; line_cnt, block_cnt and the latched num_blocks go to 0.
REQ-034 After reset: stream_encoder_src_req_rdy=1; every other control output is 0.
REQ-035 Reset mid-operation, in any state, abandons the request immediately, without draining any lines.

Verification (LINES_PER_BLOCK=4, DATA_W=256)
REQ-036 Request num_blocks=1 with out_ctrl rdy=1 and encoder rdy=1 ->
- meta handshake one cycle after request acceptance;
- 4 lines passed with first on beat 0, last on beat 3;
- READY again the cycle after beat 3.
REQ-037 Request num_blocks=3 ->
- 12 line handshakes; first on beats 0, 4, 8; last on beats 3, 7, 11;
- data values match the source beat-for-beat.
REQ-038 out_ctrl rdy held low 5 cycles in SEND_META ->
- in_ctrl_out_ctrl_val stays 1 with count stable;
- src data_rdy stays 0 throughout.
REQ-039 Encoder rdy toggled randomly ->
- no lost or duplicated lines;
- counters advance only on val&rdy;
- a request with num_blocks=0 is consumed and yields no meta.
REQ-040 rst asserted after line 2 of block 1 ->
- next cycle: READY, req_rdy=1, all vals 0;
- a new num_blocks=1 request completes normally.
